gate_truth_checker: RTL and testbench
=====================================

Name: gate_truth_checker

Overview:
- Hardware self-test sequencer for any 2-input, 1-output gate.
- On `start`, it drives the gate-under-test inputs through all four combinations in the fixed order 00, 10, 01, 11 (input1, input2).
- After each combination settles, it samples the gate output and compares it against a 4-bit expected truth table.
- It reports pass/fail, an error count and a per-step failure mask. It replaces the bench-driven stimulus with an on-chip checker that sits beside each gate module.

Parameters:
- SETTLE_CYCLES, 2, cycles each input combination is held before the output is sampled; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a test run; honoured only in IDLE
- truth_table  input  4  expected output; bit k = expected op for step k; latched on accepted start
- dut_op  input  1  output of gate under test
- dut_in1  output  1  drives gate input1
- dut_in2  output  1  drives gate input2
- busy  output  1  high from the cycle after start is accepted through the last SAMPLE cycle
- done  output  1  one-cycle pulse when the run completes
- pass  output  1  1 when the last completed run had zero mismatches; held until next accepted start
- err_count  output  3  number of mismatching steps in current/last run, 0..4
- fail_mask  output  4  bit k set if step k mismatched

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, dut_in1=0, dut_in2=0, busy=0, done=0, pass=0, err_count=0, fail_mask=0, step=0, settle counter=0. Reset overrides everything, including mid-run; no partial results survive.
- Step encoding: step k in 0..3 drives dut_in1=k[0], dut_in2=k[1]. Order is 00, 10, 01, 11.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE, start=1 sampled:
  - latch truth_table;
  - clear err_count and fail_mask; clear pass;
  - step=0; inputs=00; go to SETTLE with counter=0.
  - start=0: stay in IDLE, inputs hold their last values.
- SETTLE: inputs held constant. Counter increments each cycle. After SETTLE_CYCLES cycles in SETTLE, go to SAMPLE.
- SAMPLE (one cycle): compare dut_op with latched_tt[step].
  - On mismatch: err_count+1 and fail_mask[step]=1, both registered at the end of this cycle.
  - step<3: step+1, drive the new input pair, go to SETTLE with counter cleared.
  - step==3: go to DONE.
- DONE (one cycle):
  - done=1, busy=0;
  - pass=1 iff err_count==0, registered at entry so it is valid in the same cycle as done;
  - next state IDLE. Inputs remain at 11 until the next run.
- Latency: done is high exactly 4*(SETTLE_CYCLES+1)+1 cycles after the edge that accepted start; 13 cycles for the default.
- Ignored conditions:
  - start while busy or in DONE: ignored; no restart, no queuing;
  - changes to truth_table after acceptance: no effect on the current run;
  - start held high continuously: a new run begins on the cycle after DONE (IDLE accepts it).
- Arithmetic: err_count saturates naturally at 4 (max 4 steps), so no overflow handling is needed. The settle counter is 4 bits wide.
- Timing constraint: dut_op must be sampled only in SAMPLE. Glitches during SETTLE are never counted.

Test Plan:
1. NAND gate connected, truth_table=4'b0111, SETTLE_CYCLES=2, start pulsed:
   - dut_in sequence is 00, 10, 01, 11, each held 3 cycles;
   - done is high 13 cycles after the start edge;
   - pass=1, err_count=0, fail_mask=0000.
2. AND gate connected, truth_table=4'b0111 → err_count=4, fail_mask=1111, pass=0.
3. dut_op tied to 1, truth_table=4'b0111 → mismatch only at step 3; err_count=1, fail_mask=1000, pass=0.
4. Busy and latch checks during a run:
   - pulse start again at cycle 5 of a run → ignored, done still at cycle 13;
   - change truth_table to 0000 mid-run → results match the originally latched 0111.
5. Reset mid-run:
   - assert rst during step 2 → next cycle busy=0, dut_in=00, err_count=0, fail_mask=0, pass=0;
   - a new start afterwards yields the clean scenario-1 result.
6. Back-to-back runs:
   - hold start=1 → second run begins the cycle after DONE;
   - pass, err_count and fail_mask clear at the second acceptance;
   - done pulses are separated by 14 cycles.

Source files
------------

// File: rtl/gate_truth_checker_if.sv
// ---------------------------------------------------------------------------
// gate_truth_checker_if
//
// Purpose: bundles every signal exchanged between the on-chip gate self-test
// sequencer and its surroundings: the run request, the expected truth table,
// the two drive lines and one observe line of the gate under test, and the
// result reporting.
//
// Signals:
//   start        run request (honoured only while the checker is idle)
//   truth_table  expected gate output, bit k for step k
//   dut_op       output of the gate under test
//   dut_in1      drives gate input1
//   dut_in2      drives gate input2
//   busy         run in progress
//   done         one-cycle completion pulse
//   pass         last completed run had no mismatches
//   err_count    number of mismatching steps (0..4)
//   fail_mask    bit k set if step k mismatched
//
// Modports:
//   slave   the checker itself
//   master  whatever requests runs, supplies the gate output and reads results
// ---------------------------------------------------------------------------
interface gate_truth_checker_if;
    logic       start;
    logic [3:0] truth_table;
    logic       dut_op;
    logic       dut_in1;
    logic       dut_in2;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic [3:0] fail_mask;

    modport slave (
        input  start,
        input  truth_table,
        input  dut_op,
        output dut_in1,
        output dut_in2,
        output busy,
        output done,
        output pass,
        output err_count,
        output fail_mask
    );

    modport master (
        output start,
        output truth_table,
        output dut_op,
        input  dut_in1,
        input  dut_in2,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  fail_mask
    );
endinterface

// File: rtl/gate_truth_checker.sv
// ---------------------------------------------------------------------------
// gate_truth_checker
//
// Purpose: hardware self-test sequencer for a 2-input, 1-output gate. On an
// accepted start it walks the gate inputs through 00, 10, 01, 11
// (input1, input2), holds each pair for SETTLE_CYCLES cycles, samples the
// gate output for one cycle and compares it against the latched truth table.
// It reports a pass flag, a mismatch count and a per-step failure mask.
//
// Parameters:
//   SETTLE_CYCLES  cycles each input pair is held before sampling (1..15)
//
// Ports:
//   clk   system clock, all state changes on the rising edge
//   rst   synchronous active-high reset
//   bus   gate_truth_checker_if.slave (start, truth_table, dut_op in;
//         dut_in1, dut_in2, busy, done, pass, err_count, fail_mask out)
// ---------------------------------------------------------------------------
module gate_truth_checker #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    gate_truth_checker_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state_q,     state_d;
    logic [1:0] step_q,      step_d;
    logic [3:0] settleCnt_q, settleCnt_d;
    logic [3:0] latchedTt_q, latchedTt_d;
    logic [2:0] errCount_q,  errCount_d;
    logic [3:0] failMask_q,  failMask_d;
    logic       pass_q,      pass_d;

    // Next-state logic for the test sequencer. Every register holds by
    // default; each state only overrides what it changes. The step index
    // doubles as the input-pair encoding, so the gate inputs stay at the
    // last pair (11) after a run until the next run restarts from 00.
    // The mismatch count and mask are updated only in SAMPLE so glitches
    // on the gate output while the inputs settle are never counted. The
    // pass flag is computed from the count including the final step, so it
    // is already valid during the DONE cycle.
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        settleCnt_d = settleCnt_q;
        latchedTt_d = latchedTt_q;
        errCount_d  = errCount_q;
        failMask_d  = failMask_q;
        pass_d      = pass_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    latchedTt_d = bus.truth_table;
                    errCount_d  = 3'd0;
                    failMask_d  = 4'd0;
                    pass_d      = 1'b0;
                    step_d      = 2'd0;
                    settleCnt_d = 4'd0;
                    state_d     = SETTLE;
                end
            end

            SETTLE: begin
                settleCnt_d = settleCnt_q + 4'd1;
                if (settleCnt_q == SETTLE_LAST) begin
                    state_d = SAMPLE;
                end
            end

            SAMPLE: begin
                if (bus.dut_op != latchedTt_q[step_q]) begin
                    errCount_d         = errCount_q + 3'd1;
                    failMask_d[step_q] = 1'b1;
                end
                if (step_q != 2'd3) begin
                    step_d      = step_q + 2'd1;
                    settleCnt_d = 4'd0;
                    state_d     = SETTLE;
                end else begin
                    pass_d  = (errCount_d == 3'd0);
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register. Reset wins over everything, including a run in
    // progress, so no partial result survives a reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            step_q      <= 2'd0;
            settleCnt_q <= 4'd0;
            latchedTt_q <= 4'd0;
            errCount_q  <= 3'd0;
            failMask_q  <= 4'd0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            settleCnt_q <= settleCnt_d;
            latchedTt_q <= latchedTt_d;
            errCount_q  <= errCount_d;
            failMask_q  <= failMask_d;
            pass_q      <= pass_d;
        end
    end

    // Outputs come straight from registered state; busy covers the settle
    // and sample phases, done is the single DONE cycle.
    assign bus.dut_in1   = step_q[0];
    assign bus.dut_in2   = step_q[1];
    assign bus.busy      = (state_q == SETTLE) || (state_q == SAMPLE);
    assign bus.done      = (state_q == DONE);
    assign bus.pass      = pass_q;
    assign bus.err_count = errCount_q;
    assign bus.fail_mask = failMask_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// ---------------------------------------------------------------------------
// tb_gate_truth_checker
//
// Purpose: self-checking bench for gate_truth_checker. A behavioural gate
// (NAND, AND or constant 1) is wired to the checker's drive lines. Each run
// pushes its expected result onto a scoreboard when start is driven; the
// entry is popped and compared when done is observed.
// ---------------------------------------------------------------------------
module tb_gate_truth_checker;

    localparam int SETTLE    = 2;
    localparam int LATENCY   = 4 * (SETTLE + 1) + 1;
    localparam int MAX_WAIT  = 100;
    localparam int OFF       = -10;
    localparam int GATE_NAND = 0;
    localparam int GATE_AND  = 1;
    localparam int GATE_ONE  = 2;

    typedef struct packed {
        logic       pass;
        logic [2:0] errCount;
        logic [3:0] failMask;
    } result_t;

    logic    clk = 1'b0;
    logic    rst = 1'b1;
    int      gateMode = GATE_NAND;
    int      checkCount = 0;
    int      passCount = 0;
    int      failCount = 0;
    int      cycles;
    time     doneTime1;
    time     doneTime2;
    result_t dropped;
    result_t scoreboard[$];

    gate_truth_checker_if bus();

    gate_truth_checker #(
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Behavioural gate under test, selected per scenario.
    always_comb begin
        case (gateMode)
            GATE_NAND: bus.dut_op = ~(bus.dut_in1 & bus.dut_in2);
            GATE_AND:  bus.dut_op = bus.dut_in1 & bus.dut_in2;
            default:   bus.dut_op = 1'b1;
        endcase
    end

    function automatic logic gateOut(input int mode, input logic a, input logic b);
        case (mode)
            GATE_NAND: return ~(a & b);
            GATE_AND:  return a & b;
            default:   return 1'b1;
        endcase
    endfunction

    // Expected result of a full run: step k drives input1=k[0], input2=k[1].
    function automatic result_t expectedResult(input int mode, input logic [3:0] tt);
        result_t r;
        logic    op;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            op = gateOut(mode, k[0], k[1]);
            if (op !== tt[k]) begin
                r.errCount    = r.errCount + 3'd1;
                r.failMask[k] = 1'b1;
            end
        end
        r.pass = (r.errCount == 3'd0);
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drives start with a truth table and gate, records the expectation and
    // returns right after the accepting rising edge.
    task automatic applyStimulus(input int mode, input logic [3:0] tt);
        @(negedge clk);
        gateMode        = mode;
        bus.truth_table = tt;
        bus.start       = 1'b1;
        scoreboard.push_back(expectedResult(mode, tt));
        @(posedge clk);
    endtask

    task automatic compareResult(input string tag);
        result_t exp;
        if (scoreboard.size() > 0) exp = scoreboard.pop_front();
        else exp = 'x;
        checkOutput({tag, " pass"},      32'(bus.pass),      32'(exp.pass));
        checkOutput({tag, " err_count"}, 32'(bus.err_count), 32'(exp.errCount));
        checkOutput({tag, " fail_mask"}, 32'(bus.fail_mask), 32'(exp.failMask));
    endtask

    // Counts cycles after the accepting edge until done, with optional
    // mid-run pokes. Cycle c is sampled at the falling edge after edge c-1.
    task automatic waitDone(input string tag, input bit holdStart, input bit checkSeq,
                            input bit checkClear, input int pokeAt, input int ttAt,
                            output int cyc);
        int step;
        cyc = 0;
        for (int c = 1; c <= MAX_WAIT; c++) begin
            @(negedge clk);
            cyc = c;
            if (c == 1 && !holdStart) bus.start = 1'b0;
            if (c == 1 && checkClear) begin
                checkOutput({tag, " accept busy"},      32'(bus.busy),      32'd1);
                checkOutput({tag, " accept pass"},      32'(bus.pass),      32'd0);
                checkOutput({tag, " accept err_count"}, 32'(bus.err_count), 32'd0);
                checkOutput({tag, " accept fail_mask"}, 32'(bus.fail_mask), 32'd0);
            end
            if (checkSeq && c < LATENCY) begin
                step = (c - 1) / (SETTLE + 1);
                checkOutput($sformatf("%s c%0d dut_in1", tag, c), 32'(bus.dut_in1), 32'(step[0]));
                checkOutput($sformatf("%s c%0d dut_in2", tag, c), 32'(bus.dut_in2), 32'(step[1]));
                checkOutput($sformatf("%s c%0d busy", tag, c),    32'(bus.busy),    32'd1);
            end
            if (c == pokeAt) bus.start = 1'b1;
            if (c == pokeAt + 1) bus.start = 1'b0;
            if (c == ttAt) bus.truth_table = 4'b0000;
            if (bus.done) break;
        end
        checkOutput({tag, " latency"},   32'(cyc),      32'(LATENCY));
        checkOutput({tag, " done busy"}, 32'(bus.busy), 32'd0);
        compareResult(tag);
    endtask

    task automatic checkIdleAfterDone(input string tag, input logic expPass);
        @(negedge clk);
        checkOutput({tag, " post done"},    32'(bus.done),    32'd0);
        checkOutput({tag, " post busy"},    32'(bus.busy),    32'd0);
        checkOutput({tag, " post pass"},    32'(bus.pass),    32'(expPass));
        checkOutput({tag, " post dut_in1"}, 32'(bus.dut_in1), 32'd1);
        checkOutput({tag, " post dut_in2"}, 32'(bus.dut_in2), 32'd1);
    endtask

    // Directed scenario sequence.
    initial begin
        bus.start       = 1'b0;
        bus.truth_table = 4'b0000;
        rst             = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset busy",      32'(bus.busy),      32'd0);
        checkOutput("reset done",      32'(bus.done),      32'd0);
        checkOutput("reset pass",      32'(bus.pass),      32'd0);
        checkOutput("reset err_count", 32'(bus.err_count), 32'd0);
        checkOutput("reset fail_mask", 32'(bus.fail_mask), 32'd0);
        checkOutput("reset dut_in1",   32'(bus.dut_in1),   32'd0);
        checkOutput("reset dut_in2",   32'(bus.dut_in2),   32'd0);
        rst = 1'b0;

        // NAND gate, clean run with input sequence checked.
        applyStimulus(GATE_NAND, 4'b0111);
        waitDone("nand", 1'b0, 1'b1, 1'b0, OFF, OFF, cycles);
        checkIdleAfterDone("nand", 1'b1);

        // AND gate against a NAND table: every step mismatches.
        applyStimulus(GATE_AND, 4'b0111);
        waitDone("and", 1'b0, 1'b0, 1'b0, OFF, OFF, cycles);
        checkIdleAfterDone("and", 1'b0);

        // Output stuck at 1: only step 3 mismatches.
        applyStimulus(GATE_ONE, 4'b0111);
        waitDone("tie1", 1'b0, 1'b0, 1'b0, OFF, OFF, cycles);
        checkIdleAfterDone("tie1", 1'b0);

        // Start re-pulsed mid-run and truth table changed after acceptance.
        applyStimulus(GATE_NAND, 4'b0111);
        waitDone("latch", 1'b0, 1'b0, 1'b0, 5, 6, cycles);
        checkIdleAfterDone("latch", 1'b1);

        // Reset during step 2 of a failing run.
        applyStimulus(GATE_AND, 4'b0111);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
        end
        checkOutput("pre-reset err_count", 32'(bus.err_count), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid reset busy",      32'(bus.busy),      32'd0);
        checkOutput("mid reset done",      32'(bus.done),      32'd0);
        checkOutput("mid reset dut_in1",   32'(bus.dut_in1),   32'd0);
        checkOutput("mid reset dut_in2",   32'(bus.dut_in2),   32'd0);
        checkOutput("mid reset err_count", 32'(bus.err_count), 32'd0);
        checkOutput("mid reset fail_mask", 32'(bus.fail_mask), 32'd0);
        checkOutput("mid reset pass",      32'(bus.pass),      32'd0);
        rst     = 1'b0;
        dropped = scoreboard.pop_front();
        applyStimulus(GATE_NAND, 4'b0111);
        waitDone("rerun", 1'b0, 1'b1, 1'b0, OFF, OFF, cycles);
        checkIdleAfterDone("rerun", 1'b1);

        // Back-to-back runs with start held high.
        applyStimulus(GATE_AND, 4'b0111);
        waitDone("b2b first", 1'b1, 1'b0, 1'b1, OFF, OFF, cycles);
        doneTime1 = $time;
        gateMode  = GATE_NAND;
        scoreboard.push_back(expectedResult(GATE_NAND, 4'b0111));
        @(negedge clk);
        checkOutput("b2b gap busy", 32'(bus.busy), 32'd0);
        checkOutput("b2b gap done", 32'(bus.done), 32'd0);
        @(posedge clk);
        waitDone("b2b second", 1'b0, 1'b0, 1'b1, OFF, OFF, cycles);
        doneTime2 = $time;
        checkOutput("b2b done spacing", 32'((doneTime2 - doneTime1) / 10), 32'd14);
        checkIdleAfterDone("b2b", 1'b1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
